regs_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback requesters:
//  A = ALU/EX result path (default priority) and B = load/LSU return path.

---
 rtl/regs_wb_arbiter.sv | 68 ++++++
 tb/tb_regs_wb_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter: two-requester writeback arbiter for the register file write port with B anti-starvation
module regs_wb_arbiter #(
   parameter int ADDR_W       = 5,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid_i,
   output logic              a_ready_o,
   input  logic [ADDR_W-1:0] a_waddr_i,
   input  logic [DATA_W-1:0] a_wdata_i,
   input  logic              b_valid_i,
   output logic              b_ready_o,
   input  logic [ADDR_W-1:0] b_waddr_i,
   input  logic [DATA_W-1:0] b_wdata_i,
   output logic              reg_wen_o,
   output logic [ADDR_W-1:0] reg_waddr_o,
   output logic [DATA_W-1:0] reg_wdata_o,
   output logic              b_prio_o
);
   localparam logic A_PRI = 1'b0;
   localparam logic B_PRI = 1'b1;
   logic             state;
   logic [CNT_W-1:0] starve_cnt;
   logic             a_xfer, b_xfer, b_blocked;
   // readiness: the favoured side is always ready, the other only when the favoured side is idle
   always_comb begin
      a_ready_o = rst & (state == A_PRI | ~b_valid_i);
      b_ready_o = rst & (state == B_PRI | ~a_valid_i);
      a_xfer    = a_valid_i & a_ready_o;
      b_xfer    = b_valid_i & b_ready_o;
      b_blocked = b_valid_i & ~b_ready_o;
   end
   // priority FSM: count consecutive B denials in A_PRI, hand B one priority cycle at the limit
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= A_PRI;
         starve_cnt <= '0;
      end else if (state == A_PRI && b_blocked && starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
         state      <= B_PRI;
         starve_cnt <= '0;
      end else begin
         state      <= A_PRI;
         starve_cnt <= (state == A_PRI && b_blocked) ? starve_cnt + 1'b1 : '0;
      end
   end
   // write stage: register the winner; x0 writes are accepted but never enabled
   always_ff @(posedge clk) begin
      if (!rst) begin
         reg_wen_o   <= 1'b0;
         reg_waddr_o <= '0;
         reg_wdata_o <= '0;
      end else if (b_xfer) begin
         reg_wen_o   <= b_waddr_i != '0;
         reg_waddr_o <= b_waddr_i;
         reg_wdata_o <= b_wdata_i;
      end else if (a_xfer) begin
         reg_wen_o   <= a_waddr_i != '0;
         reg_waddr_o <= a_waddr_i;
         reg_wdata_o <= a_wdata_i;
      end else begin
         reg_wen_o   <= 1'b0;
      end
   end
   assign b_prio_o = state;
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// tb_regs_wb_arbiter: directed tests plus a per-cycle behavioural model check of regs_wb_arbiter
module tb_regs_wb_arbiter;
   localparam int L = 4;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic        a_ready, b_ready;
   logic [4:0]  a_waddr = '0, b_waddr = '0;
   logic [31:0] a_wdata = '0, b_wdata = '0;
   logic        reg_wen, b_prio;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata;
   int          checks = 0, fails = 0;
   bit          go = 1'b0;
   int          denied = 0;
   logic        e_wen = 1'b0;
   logic [4:0]  e_addr = '0;
   logic [31:0] e_data = '0;

   regs_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(L), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .a_valid_i(a_valid), .a_ready_o(a_ready), .a_waddr_i(a_waddr), .a_wdata_i(a_wdata),
      .b_valid_i(b_valid), .b_ready_o(b_ready), .b_waddr_i(b_waddr), .b_wdata_i(b_wdata),
      .reg_wen_o(reg_wen), .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata), .b_prio_o(b_prio)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: B gets priority once it has been refused L cycles in a row; the write port shows last cycle's winner
   always @(posedge clk) begin
      logic ar, br;
      if (!rst) begin
         denied = 0;
         e_wen  = 1'b0;
         e_addr = '0;
         e_data = '0;
      end else begin
         ar = (denied != L) || !b_valid;
         br = (denied == L) || !a_valid;
         if (b_valid && br) begin
            e_wen = b_waddr != 0; e_addr = b_waddr; e_data = b_wdata;
         end else if (a_valid && ar) begin
            e_wen = a_waddr != 0; e_addr = a_waddr; e_data = a_wdata;
         end else
            e_wen = 1'b0;
         denied = (b_valid && !br) ? denied + 1 : 0;
      end
   end

   // compare process: every cycle after the first reset edge
   always @(negedge clk) begin
      if (go) begin
         chk("m_a_ready", a_ready, rst & ((denied != L) | ~b_valid));
         chk("m_b_ready", b_ready, rst & ((denied == L) | ~a_valid));
         chk("m_b_prio", b_prio, denied == L);
         chk("m_wen", reg_wen, e_wen);
         chk("m_waddr", reg_waddr, e_addr);
         chk("m_wdata", reg_wdata, e_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      step();
      go = 1'b1;
      step();
      @(negedge clk);
      chk("rst_wen", reg_wen, 0);
      chk("rst_waddr", reg_waddr, 0);
      chk("rst_prio", b_prio, 0);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      step();
      rst = 1'b1;
      // 1: A only
      a_valid = 1; a_waddr = 3; a_wdata = 32'h11;
      @(negedge clk);
      chk("t1_a_ready", a_ready, 1);
      step();
      a_valid = 0;
      @(negedge clk);
      chk("t1_wen", reg_wen, 1);
      chk("t1_waddr", reg_waddr, 3);
      chk("t1_wdata", reg_wdata, 32'h11);
      step();
      // 2: B only, r4..r6 back to back
      for (int i = 0; i < 3; i++) begin
         b_valid = 1; b_waddr = 5'(4 + i); b_wdata = 32'h40 + i;
         @(negedge clk);
         chk("t2_b_ready", b_ready, 1);
         if (i > 0) begin
            chk("t2_wen", reg_wen, 1);
            chk("t2_waddr", reg_waddr, 4 + i - 1);
         end
         step();
      end
      b_valid = 0;
      @(negedge clk);
      chk("t2_last_wen", reg_wen, 1);
      chk("t2_last_waddr", reg_waddr, 6);
      chk("t2_last_wdata", reg_wdata, 32'h42);
      step();
      // 3: contention, B must win on the fifth cycle only
      a_valid = 1; a_waddr = 7; a_wdata = 32'h70;
      b_valid = 1; b_waddr = 8; b_wdata = 32'h80;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t3_a_ready", a_ready, i != 4);
         chk("t3_b_ready", b_ready, i == 4);
         chk("t3_b_prio", b_prio, i == 4);
         if (i == 5) chk("t3_b_write", reg_waddr, 8);
         step();
      end
      a_valid = 0; b_valid = 0;
      step();
      // 4: x0 write is accepted but not enabled
      a_valid = 1; a_waddr = 0; a_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("t4_a_ready", a_ready, 1);
      step();
      a_waddr = 1; a_wdata = 32'h22;
      @(negedge clk);
      chk("t4_x0_wen", reg_wen, 0);
      step();
      a_valid = 0;
      @(negedge clk);
      chk("t4_r1_wen", reg_wen, 1);
      chk("t4_r1_waddr", reg_waddr, 1);
      step();
      // 5: same-address collision, A then B
      a_valid = 1; a_waddr = 5; a_wdata = 32'hA;
      b_valid = 1; b_waddr = 5; b_wdata = 32'hB;
      @(negedge clk);
      chk("t5_a_ready", a_ready, 1);
      chk("t5_b_ready", b_ready, 0);
      step();
      a_valid = 0;
      @(negedge clk);
      chk("t5_first", reg_wdata, 32'hA);
      chk("t5_b_ready2", b_ready, 1);
      step();
      b_valid = 0;
      @(negedge clk);
      chk("t5_second", reg_wdata, 32'hB);
      chk("t5_second_wen", reg_wen, 1);
      step();
      // 6: reset with the starvation count at 3
      a_valid = 1; a_waddr = 9; a_wdata = 32'h90;
      b_valid = 1; b_waddr = 10; b_wdata = 32'hA0;
      repeat (3) step();
      rst = 0;
      @(negedge clk);
      chk("t6_a_ready_rst", a_ready, 0);
      chk("t6_b_ready_rst", b_ready, 0);
      step();
      rst = 1;
      @(negedge clk);
      chk("t6_wen", reg_wen, 0);
      chk("t6_prio", b_prio, 0);
      n = 0;
      while (!b_ready && n < 10) begin
         step();
         @(negedge clk);
         n++;
      end
      chk("t6_b_wait", n, 4);
      step();
      a_valid = 0; b_valid = 0;
      repeat (2) step();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
